uart_tx_serializer: RTL and testbench

//  UART transmit serializer that drains the TX fifo and shifts each word out on the tx line.
//  It sits directly downstream of the TX fifo: it watches the fifo empty flag, pops one word,
//  and serializes it as a start bit, DATA_WIDTH data bits (LSB first), an optional parity bit
//  and STOP_BITS stop bits. A baud counter sets the bit timing from the system clock.

---
 rtl/uart_tx_serializer.sv | 98 +++++++++
 tb/tb_uart_tx_serializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: drains a TX fifo and shifts each word onto the serial line as
// start bit, data bits LSB first, optional parity bit and one or two stop bits.
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 104,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                r_state;
    logic [BW-1:0]         r_baud_cnt;
    logic [IW-1:0]         r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_stop_idx;
    logic                  r_tx;
    logic                  r_frame_done;
    logic                  w_bit_end;

    assign w_bit_end  = r_baud_cnt == BAUD_LAST;
    assign fifo_rd_en = !rst && r_state == IDLE && !fifo_empty;
    assign busy       = r_state != IDLE;
    assign tx         = r_tx;
    assign frame_done = r_frame_done;

    // tx is updated on the edge that enters each bit, so every bit lasts exactly one baud period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_stop_idx   <= 1'b0;
            r_tx         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_baud_cnt   <= (r_state == IDLE || w_bit_end) ? '0 : r_baud_cnt + 1'b1;
            case (r_state)
                IDLE: if (!fifo_empty) begin
                    r_shift  <= fifo_dout;
                    r_parity <= PARITY_ODD ? ~^fifo_dout : ^fifo_dout;
                    r_tx     <= 1'b0;
                    r_state  <= START;
                end
                START: if (w_bit_end) begin
                    r_tx      <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= '0;
                    r_state   <= DATA;
                end
                DATA: if (w_bit_end) begin
                    if (r_bit_idx == IDX_LAST) begin
                        r_tx       <= PARITY_EN ? r_parity : 1'b1;
                        r_stop_idx <= 1'b0;
                        r_state    <= PARITY_EN ? PARITY : STOP;
                    end else begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                PARITY: if (w_bit_end) begin
                    r_tx       <= 1'b1;
                    r_stop_idx <= 1'b0;
                    r_state    <= STOP;
                end
                STOP: if (w_bit_end) begin
                    if (r_stop_idx == STOP_LAST) begin
                        r_frame_done <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_stop_idx <= r_stop_idx + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frame checks on four serializer configurations
// (8N1, 8E1, 8O1, 8N2), each fed by a small queue-based fifo model.
module tb_uart_tx_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] empty = 4'hF;
    logic [7:0] dout [4] = '{default: 8'h00};
    wire  [3:0] tx, rd, busy, fd;
    logic [7:0] q [4][$];
    logic       tx_log [4][$];
    logic       fd_log [4][$];
    logic       rd_log [4][$];
    logic [3:0] prev_busy = 4'h0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(4)) u_8n1 (
        .clk(clk), .rst(rst), .fifo_dout(dout[0]), .fifo_empty(empty[0]),
        .fifo_rd_en(rd[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(fd[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_8e1 (
        .clk(clk), .rst(rst), .fifo_dout(dout[1]), .fifo_empty(empty[1]),
        .fifo_rd_en(rd[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(fd[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_8o1 (
        .clk(clk), .rst(rst), .fifo_dout(dout[2]), .fifo_empty(empty[2]),
        .fifo_rd_en(rd[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(fd[2]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .fifo_dout(dout[3]), .fifo_empty(empty[3]),
        .fifo_rd_en(rd[3]), .tx(tx[3]), .busy(busy[3]), .frame_done(fd[3]));

    // fifo model pops when a frame starts; all outputs are logged just before each rising edge
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (busy[k] && !prev_busy[k] && q[k].size() > 0) void'(q[k].pop_front());
            prev_busy[k] = busy[k];
            empty[k]     = q[k].size() == 0;
            dout[k]      = empty[k] ? 8'h00 : q[k][0];
        end
        #4;
        for (int k = 0; k < 4; k++) begin
            tx_log[k].push_back(tx[k]);
            fd_log[k].push_back(fd[k]);
            rd_log[k].push_back(rd[k]);
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 4; k++) begin
            tx_log[k].delete();
            fd_log[k].delete();
            rd_log[k].delete();
        end
    endtask

    function automatic int first_idx(input logic v [$], input logic val);
        for (int i = 0; i < v.size(); i++) if (v[i] === val) return i;
        return -1;
    endfunction

    function automatic int count_val(input logic v [$], input logic val);
        int c = 0;
        for (int i = 0; i < v.size(); i++) if (v[i] === val) c++;
        return c;
    endfunction

    function automatic logic [127:0] grab(input logic v [$], input int s, input int n);
        logic [127:0] r = '0;
        for (int i = 0; i < n; i++) r[i] = (s >= 0 && s + i < v.size()) ? v[s + i] : 1'bx;
        return r;
    endfunction

    // expected tx waveform at 4 clks per bit, bit i of the result is clock i of the frame
    function automatic logic [127:0] frame(input logic [7:0] w, input int n_par, input logic par, input int n_stop);
        logic [127:0] r = '0;
        int b = 4;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 4; c++) r[b + c] = w[i];
            b += 4;
        end
        if (n_par != 0) begin
            for (int c = 0; c < 4; c++) r[b + c] = par;
            b += 4;
        end
        for (int i = 0; i < 4 * n_stop; i++) r[b + i] = 1'b1;
        return r;
    endfunction

    initial begin
        int s;
        int s1;
        int s2;
        int s3;
        logic [127:0] g;
        logic [9:0] mid;
        logic found;

        // reset with an empty fifo
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx", tx, 4'hF);
        chk("rst_busy", busy, 4'h0);
        chk("rst_rd", rd, 4'h0);
        chk("rst_fd", fd, 4'h0);
        clear_logs();
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        chk("idle_tx_lows", count_val(tx_log[0], 1'b0), 0);
        chk("idle_rd", count_val(rd_log[0], 1'b1), 0);
        chk("idle_fd", count_val(fd_log[0], 1'b1), 0);
        chk("idle_busy", busy, 4'h0);

        // single 8N1 word 0xA5
        clear_logs();
        q[0].push_back(8'hA5);
        repeat (60) @(posedge clk);
        #2;
        s = first_idx(tx_log[0], 1'b0);
        chk("a5_frame", grab(tx_log[0], s, 41), frame(8'hA5, 0, 1'b0, 1) | (128'd1 << 40));
        g = grab(tx_log[0], s, 40);
        for (int i = 0; i < 10; i++) mid[i] = g[4 * i + 1];
        chk("a5_bits", mid, 10'b11_0100_1010);
        chk("a5_rd_pulses", count_val(rd_log[0], 1'b1), 1);
        chk("a5_pop_lead", s - first_idx(rd_log[0], 1'b1), 1);
        chk("a5_fd_pulses", count_val(fd_log[0], 1'b1), 1);
        chk("a5_fd_time", first_idx(fd_log[0], 1'b1) - s, 40);

        // back-to-back 0x00 then 0xFF with one idle clk between frames
        clear_logs();
        q[0].push_back(8'h00);
        q[0].push_back(8'hFF);
        repeat (110) @(posedge clk);
        #2;
        s = first_idx(tx_log[0], 1'b0);
        chk("b2b_frames", grab(tx_log[0], s, 82),
            frame(8'h00, 0, 1'b0, 1) | (128'd1 << 40) | (frame(8'hFF, 0, 1'b0, 1) << 41) | (128'd1 << 81));
        chk("b2b_rd_pulses", count_val(rd_log[0], 1'b1), 2);
        chk("b2b_fd_pulses", count_val(fd_log[0], 1'b1), 2);

        // parity (even/odd on 0x07) and two stop bits on 0x3C
        clear_logs();
        q[1].push_back(8'h07);
        q[2].push_back(8'h07);
        q[3].push_back(8'h3C);
        repeat (70) @(posedge clk);
        #2;
        s1 = first_idx(tx_log[1], 1'b0);
        s2 = first_idx(tx_log[2], 1'b0);
        s3 = first_idx(tx_log[3], 1'b0);
        chk("even_frame", grab(tx_log[1], s1, 45), frame(8'h07, 1, 1'b1, 1) | (128'd1 << 44));
        g = grab(tx_log[1], s1, 44);
        chk("even_par_bit", g[37], 1'b1);
        chk("odd_frame", grab(tx_log[2], s2, 45), frame(8'h07, 1, 1'b0, 1) | (128'd1 << 44));
        g = grab(tx_log[2], s2, 44);
        chk("odd_par_bit", g[37], 1'b0);
        chk("even_fd_time", first_idx(fd_log[1], 1'b1) - s1, 44);
        chk("stop2_frame", grab(tx_log[3], s3, 45), frame(8'h3C, 0, 1'b0, 2) | (128'd1 << 44));
        chk("stop2_fd_time", first_idx(fd_log[3], 1'b1) - s3, 44);
        chk("stop2_fd_pulses", count_val(fd_log[3], 1'b1), 1);
        chk("stop2_rd_pulses", count_val(rd_log[3], 1'b1), 1);

        // reset during data bit 3 with a second word still queued
        clear_logs();
        q[0].push_back(8'h33);
        q[0].push_back(8'hC3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #2;
            found = tx[0] == 1'b0;
        end
        chk("mid_start_seen", found, 1'b1);
        repeat (17) @(posedge clk);
        #2;
        chk("pre_rst_bit3", tx[0], 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_tx", tx[0], 1'b1);
        chk("rst_mid_busy", busy[0], 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_mid_rd", rd[0], 1'b0);
        clear_logs();
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #2;
        s = first_idx(tx_log[0], 1'b0);
        chk("post_rst_pop_idx", first_idx(rd_log[0], 1'b1), 0);
        chk("post_rst_start_idx", s, 1);
        chk("post_rst_frame", grab(tx_log[0], s, 41), frame(8'hC3, 0, 1'b0, 1) | (128'd1 << 40));
        chk("post_rst_rd_pulses", count_val(rd_log[0], 1'b1), 1);
        chk("post_rst_fd_pulses", count_val(fd_log[0], 1'b1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
